ime_part_seq: RTL and testbench
===============================

// Module: ime_part_seq
// PURPOSE
//  Consumes the per-MB mode decision from integer motion estimation (mb_type / sub_mb_type).
//  Expands it into the ordered list of motion partitions, one per handshake, for downstream
//  fractional ME / MC. Each partition is given as a 4x4-block-grid position, size and index.
//  Sits between the IME mode decision and the FME partition loop; one MB in flight at a time.
// PARAMETERS
//  MB_TYPE_LEN      3  width of mb_type; codes 0=PART16X16 1=PART16X8 2=PART8X16 3=PART8X8
//  SUB_MB_TYPE_LEN  3  width of each sub_mb_type field; 0=SUB8X8 1=SUB8X4 2=SUB4X8 3=SUB4X4
// PORTS
//  clk            in   1                  clock, all logic on rising edge
//  rst            in   1                  synchronous reset, active-high
//  start_i        in   1                  load a new MB decision; accepted only when busy_o=0
//  mb_type_i      in   MB_TYPE_LEN        MB partition type, sampled on accepted start
//  sub_mb_type_i  in   4*SUB_MB_TYPE_LEN  field i = [i*3+:3] is sub type of 8x8 block i (raster)
//  busy_o         out  1                  high from accepted start until the last partition is accepted
//  part_valid_o   out  1                  partition descriptor valid
//  part_ready_i   in   1                  consumer accepts descriptor when valid&ready
//  part_x_o       out  2                  left edge, 4-pel units (0..3)
//  part_y_o       out  2                  top edge, 4-pel units (0..3)
//  part_w_o       out  2                  width in 4-pel units minus 1 (0=4 pel .. 3=16 pel)
//  part_h_o       out  2                  height in 4-pel units minus 1
//  part_idx_o     out  4                  partition ordinal within the MB, 0..15
//  part_last_o    out  1                  descriptor is the final partition of the MB
//  done_o         out  1                  one-cycle pulse in the cycle after the last handshake
// BEHAVIOUR
//  Reset: busy_o, part_valid_o, part_last_o, done_o = 0; x/y/w/h/idx = 0; FSM -> IDLE.
//  Reset mid-MB aborts the sequence; no done_o is produced for the aborted MB.
//  FSM: IDLE -> (start_i) SEND -> (handshake with part_last_o) IDLE.
//   IDLE: latch mb_type_i, sub_mb_type_i on start_i; busy_o=1 and part_valid_o=1 from next cycle.
//   SEND: descriptor held stable while valid & !ready. On each handshake, advance to the next partition.
//    If the partition was last, drop valid and busy next cycle and pulse done_o.
//  Latency: start at cycle N -> first descriptor valid at N+1.
//   With ready tied high: one partition per cycle; done_o at N+1+P, where P = partition count.
//  start_i while busy_o=1 is ignored, and inputs are not re-sampled.
//   A start in the done_o cycle is accepted, since busy_o=0 in that cycle.
//  Order and geometry (x,y,w,h):
//   PART16X16: (0,0,3,3).
//   PART16X8: (0,0,3,1),(0,2,3,1).
//   PART8X16: (0,0,1,3),(2,0,1,3).
//   PART8X8: 8x8 blocks i=0..3 at bx=2*(i%2), by=2*(i/2), each fully emitted before i+1:
//    SUB8X8 (bx,by,1,1); SUB8X4 (bx,by,1,0),(bx,by+1,1,0);
//    SUB4X8 (bx,by,0,1),(bx+1,by,0,1); SUB4X4 raster (bx,by),(bx+1,by),(bx,by+1),(bx+1,by+1), w=h=0.
//  part_idx_o counts 0..P-1 continuously across 8x8 blocks, so P ranges 1..16.
//  Reserved codes: mb_type 4..7 behaves as PART16X16; sub type 4..7 behaves as SUB8X8.
//  part_ready_i is ignored when part_valid_o=0.
//  Outputs are registered; no combinational path from part_ready_i to any output.
// TESTING
//  1. mb_type=0, ready=1: one descriptor (0,0,3,3) idx0 last=1 at N+1, done_o at N+2, busy low at N+2.
//  2. mb_type=1 then 2: (0,0,3,1),(0,2,3,1) / (0,0,1,3),(2,0,1,3); idx 0,1; last on the 2nd only.
//  3. mb_type=3, sub={blk3=3,blk2=2,blk1=1,blk0=0} (12'o3210): 9 descriptors.
//     (0,0,1,1),(2,0,1,0),(2,1,1,0),(0,2,0,1),(1,2,0,1),(2,2,0,0),(3,2,0,0),(2,3,0,0),(3,3,0,0); idx0..8.
//  4. Case 3 with random ready (~40% high): descriptors unchanged while stalled; identical sequence; exactly one done_o.
//  5. start_i pulsed mid-sequence with different types -> ignored. start in the done_o cycle -> new MB valid next cycle.
//  6. rst asserted at the 3rd descriptor of case 3 -> all outputs 0 next cycle, no done_o; mb_type=5 -> as 16x16.

Source files
------------

// File: rtl/ime_part_seq.sv
// ============================================================================
// Module   : ime_part_seq
// Brief    : Expands an IME mb_type/sub_mb_type decision into an ordered
//            stream of motion-partition descriptors on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ime_part_seq #(
    parameter int MB_TYPE_LEN     = 3,
    parameter int SUB_MB_TYPE_LEN = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [MB_TYPE_LEN-1:0]       mb_type_i,
    input  logic [4*SUB_MB_TYPE_LEN-1:0] sub_mb_type_i,
    output logic                         busy_o,
    output logic                         part_valid_o,
    input  logic                         part_ready_i,
    output logic [1:0]                   part_x_o,
    output logic [1:0]                   part_y_o,
    output logic [1:0]                   part_w_o,
    output logic [1:0]                   part_h_o,
    output logic [3:0]                   part_idx_o,
    output logic                         part_last_o,
    output logic                         done_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [MB_TYPE_LEN-1:0]     c_MB_MAX  = MB_TYPE_LEN'(3);
    localparam logic [SUB_MB_TYPE_LEN-1:0] c_SUB_MAX = SUB_MB_TYPE_LEN'(3);

    // Geometry of partition (blk, sb) packed as {x, y, w, h, unit_last, mb_last}.
    // A "unit" is the whole MB for non-8x8 types, otherwise one 8x8 block.
    function automatic logic [9:0] part_geo(
        input logic [MB_TYPE_LEN-1:0]       mbt,
        input logic [4*SUB_MB_TYPE_LEN-1:0] subs,
        input logic [1:0]                   blk,
        input logic [1:0]                   sb
    );
        logic [1:0]                 t;
        logic [SUB_MB_TYPE_LEN-1:0] st;
        logic [1:0]                 x, y, w, h, bx, by;
        logic                       ul;
        t  = (mbt > c_MB_MAX) ? 2'd0 : mbt[1:0];
        st = subs[int'(blk)*SUB_MB_TYPE_LEN +: SUB_MB_TYPE_LEN];
        bx = {blk[0], 1'b0};
        by = {blk[1], 1'b0};
        x  = 2'd0;
        y  = 2'd0;
        w  = 2'd3;
        h  = 2'd3;
        ul = 1'b1;
        case (t)
            2'd1: begin
                y  = {sb[0], 1'b0};
                h  = 2'd1;
                ul = sb[0];
            end
            2'd2: begin
                x  = {sb[0], 1'b0};
                w  = 2'd1;
                ul = sb[0];
            end
            2'd3: begin
                if (st == SUB_MB_TYPE_LEN'(1)) begin
                    x  = bx;
                    y  = by | {1'b0, sb[0]};
                    w  = 2'd1;
                    h  = 2'd0;
                    ul = sb[0];
                end else if (st == SUB_MB_TYPE_LEN'(2)) begin
                    x  = bx | {1'b0, sb[0]};
                    y  = by;
                    w  = 2'd0;
                    h  = 2'd1;
                    ul = sb[0];
                end else if (st == c_SUB_MAX) begin
                    x  = bx | {1'b0, sb[0]};
                    y  = by | {1'b0, sb[1]};
                    w  = 2'd0;
                    h  = 2'd0;
                    ul = &sb;
                end else begin
                    x  = bx;
                    y  = by;
                    w  = 2'd1;
                    h  = 2'd1;
                    ul = 1'b1;
                end
            end
            default: begin
                ul = 1'b1;
            end
        endcase
        return {x, y, w, h, ul, ul && ((t != 2'd3) || (blk == 2'd3))};
    endfunction

    logic [0:0]                   r_state;
    logic [0:0]                   w_state_nxt;
    logic [MB_TYPE_LEN-1:0]       r_mb;
    logic [4*SUB_MB_TYPE_LEN-1:0] r_sub;
    logic [1:0]                   r_blk;
    logic [1:0]                   r_sb;
    logic                         r_unit_last;
    logic [1:0]                   r_x, r_y, r_w, r_h;
    logic [3:0]                   r_idx;
    logic                         r_last;
    logic                         r_done;

    logic                         w_hs;
    logic                         w_load;
    logic                         w_adv;
    logic [MB_TYPE_LEN-1:0]       w_mb_sel;
    logic [4*SUB_MB_TYPE_LEN-1:0] w_sub_sel;
    logic [1:0]                   w_blk_sel;
    logic [1:0]                   w_sb_sel;
    logic [9:0]                   w_geo;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start_i)          w_state_nxt = ST_SEND;
            ST_SEND: if (w_hs && r_last)   w_state_nxt = ST_IDLE;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    // Control strobes
    always_comb begin
        w_hs   = 1'b0;
        w_load = 1'b0;
        w_adv  = 1'b0;
        case (r_state)
            ST_IDLE: w_load = start_i;
            ST_SEND: begin
                w_hs  = part_ready_i;
                w_adv = part_ready_i && !r_last;
            end
            default: ;
        endcase
    end

    // One geometry evaluator serves both the first partition (from the live
    // inputs) and every subsequent one (from the latched decision).
    always_comb begin
        w_mb_sel  = w_load ? mb_type_i     : r_mb;
        w_sub_sel = w_load ? sub_mb_type_i : r_sub;
        w_blk_sel = w_load ? 2'd0 : (r_unit_last ? r_blk + 2'd1 : r_blk);
        w_sb_sel  = (w_load || r_unit_last) ? 2'd0 : r_sb + 2'd1;
        w_geo     = part_geo(w_mb_sel, w_sub_sel, w_blk_sel, w_sb_sel);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mb        <= '0;
            r_sub       <= '0;
            r_blk       <= 2'd0;
            r_sb        <= 2'd0;
            r_unit_last <= 1'b0;
            r_x         <= 2'd0;
            r_y         <= 2'd0;
            r_w         <= 2'd0;
            r_h         <= 2'd0;
            r_idx       <= 4'd0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_hs && r_last;
            if (w_load || w_adv) begin
                if (w_load) begin
                    r_mb  <= mb_type_i;
                    r_sub <= sub_mb_type_i;
                    r_idx <= 4'd0;
                end else begin
                    r_idx <= r_idx + 4'd1;
                end
                r_blk       <= w_blk_sel;
                r_sb        <= w_sb_sel;
                {r_x, r_y, r_w, r_h, r_unit_last, r_last} <= w_geo;
            end
        end
    end

    assign busy_o       = (r_state == ST_SEND);
    assign part_valid_o = (r_state == ST_SEND);
    assign part_x_o     = r_x;
    assign part_y_o     = r_y;
    assign part_w_o     = r_w;
    assign part_h_o     = r_h;
    assign part_idx_o   = r_idx;
    assign part_last_o  = r_last;
    assign done_o       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ime_part_seq.sv
// ============================================================================
// Module   : tb_ime_part_seq
// Brief    : Directed self-checking bench for ime_part_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ime_part_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  mb_type_i;
    logic [11:0] sub_mb_type_i;
    logic        busy_o;
    logic        part_valid_o;
    logic        part_ready_i;
    logic [1:0]  part_x_o, part_y_o, part_w_o, part_h_o;
    logic [3:0]  part_idx_o;
    logic        part_last_o;
    logic        done_o;
    logic [7:0]  geo;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [7:0]  exp_geo [0:15];

    always #5 clk = ~clk;

    assign geo = {part_x_o, part_y_o, part_w_o, part_h_o};

    ime_part_seq #(
        .MB_TYPE_LEN     (3),
        .SUB_MB_TYPE_LEN (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .mb_type_i     (mb_type_i),
        .sub_mb_type_i (sub_mb_type_i),
        .busy_o        (busy_o),
        .part_valid_o  (part_valid_o),
        .part_ready_i  (part_ready_i),
        .part_x_o      (part_x_o),
        .part_y_o      (part_y_o),
        .part_w_o      (part_w_o),
        .part_h_o      (part_h_o),
        .part_idx_o    (part_idx_o),
        .part_last_o   (part_last_o),
        .done_o        (done_o)
    );

    // Hand-derived table for mb_type=3, sub=12'o3210; geometry packed {x,y,w,h}.
    task automatic fill_8x8_table();
        exp_geo[0] = 8'h05; exp_geo[1] = 8'h84; exp_geo[2] = 8'h94;
        exp_geo[3] = 8'h21; exp_geo[4] = 8'h61; exp_geo[5] = 8'hA0;
        exp_geo[6] = 8'hE0; exp_geo[7] = 8'hB0; exp_geo[8] = 8'hF0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; mb_type_i = 3'd0; sub_mb_type_i = 12'd0; part_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({busy_o, part_valid_o, part_last_o, done_o, geo, part_idx_o} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset: outputs=%h want 0000", {busy_o, part_valid_o, part_last_o, done_o, geo, part_idx_o});
        end
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (busy_o !== 1'b0 || part_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b valid=%b want 0 0", busy_o, part_valid_o);
        end
    endtask

    task automatic test_16x16();
        part_ready_i = 1'b1; start_i = 1'b1; mb_type_i = 3'd0;
        @(negedge clk);
        start_i = 1'b0;
        n_chk++;
        if (part_valid_o !== 1'b1 || busy_o !== 1'b1 || geo !== 8'h0F || part_idx_o !== 4'd0 || part_last_o !== 1'b1 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL 16x16 desc: v=%b b=%b geo=%h idx=%0d last=%b done=%b want 1 1 0f 0 1 0",
                     part_valid_o, busy_o, geo, part_idx_o, part_last_o, done_o);
        end
        @(negedge clk);
        n_chk++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || part_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL 16x16 done: done=%b busy=%b valid=%b want 1 0 0", done_o, busy_o, part_valid_o);
        end
        @(negedge clk);
        n_chk++;
        if (done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL 16x16 done_pulse: done=%b want 0", done_o);
        end
    endtask

    task automatic test_16x8_8x16();
        for (int t = 1; t <= 2; t++) begin
            exp_geo[0] = (t == 1) ? 8'h0D : 8'h07;
            exp_geo[1] = (t == 1) ? 8'h2D : 8'h87;
            part_ready_i = 1'b1; start_i = 1'b1; mb_type_i = 3'(t);
            @(negedge clk);
            start_i = 1'b0;
            for (int k = 0; k < 2; k++) begin
                n_chk++;
                if (part_valid_o !== 1'b1 || geo !== exp_geo[k] || part_idx_o !== 4'(k) || part_last_o !== (k == 1) || done_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL type%0d desc%0d: v=%b geo=%h idx=%0d last=%b done=%b want 1 %h %0d %b 0",
                             t, k, part_valid_o, geo, part_idx_o, part_last_o, done_o, exp_geo[k], k, (k == 1));
                end
                @(negedge clk);
            end
            n_chk++;
            if (done_o !== 1'b1 || busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL type%0d done: done=%b busy=%b want 1 0", t, done_o, busy_o);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_8x8();
        fill_8x8_table();
        part_ready_i = 1'b1; start_i = 1'b1; mb_type_i = 3'd3; sub_mb_type_i = 12'o3210;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < 9; k++) begin
            n_chk++;
            if (part_valid_o !== 1'b1 || busy_o !== 1'b1 || geo !== exp_geo[k] || part_idx_o !== 4'(k) || part_last_o !== (k == 8) || done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL 8x8 desc%0d: v=%b b=%b geo=%h idx=%0d last=%b done=%b want 1 1 %h %0d %b 0",
                         k, part_valid_o, busy_o, geo, part_idx_o, part_last_o, done_o, exp_geo[k], k, (k == 8));
            end
            @(negedge clk);
        end
        n_chk++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || part_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL 8x8 done: done=%b busy=%b valid=%b want 1 0 0", done_o, busy_o, part_valid_o);
        end
        @(negedge clk);
    endtask

    task automatic test_8x8_stall();
        int  k;
        int  cyc;
        int  ndone;
        logic r;
        fill_8x8_table();
        part_ready_i = 1'b0; start_i = 1'b1; mb_type_i = 3'd3; sub_mb_type_i = 12'o3210;
        @(negedge clk);
        start_i = 1'b0;
        k = 0; cyc = 0; ndone = 0;
        while (k < 9 && cyc < 400) begin
            n_chk++;
            if (part_valid_o !== 1'b1 || geo !== exp_geo[k] || part_idx_o !== 4'(k) || part_last_o !== (k == 8) || done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall desc%0d cyc%0d: v=%b geo=%h idx=%0d last=%b done=%b want 1 %h %0d %b 0",
                         k, cyc, part_valid_o, geo, part_idx_o, part_last_o, done_o, exp_geo[k], k, (k == 8));
            end
            r = ($urandom_range(0, 9) < 4);
            part_ready_i = r;
            @(negedge clk);
            cyc++;
            if (r) k++;
        end
        n_chk++;
        if (k < 9) begin
            n_fail++;
            $display("FAIL stall timeout: accepted=%0d want 9", k);
        end
        part_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done_o === 1'b1) ndone++;
            @(negedge clk);
        end
        n_chk++;
        if (ndone !== 1) begin
            n_fail++;
            $display("FAIL stall done_count: got %0d want 1", ndone);
        end
    endtask

    task automatic test_restart();
        fill_8x8_table();
        part_ready_i = 1'b1; start_i = 1'b1; mb_type_i = 3'd3; sub_mb_type_i = 12'o3210;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < 9; k++) begin
            n_chk++;
            if (part_valid_o !== 1'b1 || geo !== exp_geo[k] || part_idx_o !== 4'(k) || part_last_o !== (k == 8)) begin
                n_fail++;
                $display("FAIL ignore_start desc%0d: v=%b geo=%h idx=%0d last=%b want 1 %h %0d %b",
                         k, part_valid_o, geo, part_idx_o, part_last_o, exp_geo[k], k, (k == 8));
            end
            start_i = (k == 3);
            if (k == 3) begin
                mb_type_i = 3'd0; sub_mb_type_i = 12'd0;
            end
            @(negedge clk);
        end
        n_chk++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL restart done: done=%b busy=%b want 1 0", done_o, busy_o);
        end
        start_i = 1'b1; mb_type_i = 3'd1;
        @(negedge clk);
        start_i = 1'b0;
        n_chk++;
        if (part_valid_o !== 1'b1 || geo !== 8'h0D || part_idx_o !== 4'd0 || part_last_o !== 1'b0) begin
            n_fail++;
            $display("FAIL restart desc0: v=%b geo=%h idx=%0d last=%b want 1 0d 0 0", part_valid_o, geo, part_idx_o, part_last_o);
        end
        @(negedge clk);
        n_chk++;
        if (part_valid_o !== 1'b1 || geo !== 8'h2D || part_idx_o !== 4'd1 || part_last_o !== 1'b1) begin
            n_fail++;
            $display("FAIL restart desc1: v=%b geo=%h idx=%0d last=%b want 1 2d 1 1", part_valid_o, geo, part_idx_o, part_last_o);
        end
        @(negedge clk);
        n_chk++;
        if (done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL restart done2: done=%b want 1", done_o);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        fill_8x8_table();
        part_ready_i = 1'b1; start_i = 1'b1; mb_type_i = 3'd3; sub_mb_type_i = 12'o3210;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (part_valid_o !== 1'b1 || geo !== exp_geo[k] || part_idx_o !== 4'(k)) begin
                n_fail++;
                $display("FAIL rstmid desc%0d: v=%b geo=%h idx=%0d want 1 %h %0d", k, part_valid_o, geo, part_idx_o, exp_geo[k], k);
            end
            if (k == 2) rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        n_chk++;
        if ({busy_o, part_valid_o, part_last_o, done_o, geo, part_idx_o} !== 16'd0) begin
            n_fail++;
            $display("FAIL rstmid clear: outputs=%h want 0000", {busy_o, part_valid_o, part_last_o, done_o, geo, part_idx_o});
        end
        @(negedge clk);
        n_chk++;
        if (done_o !== 1'b0 || part_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid no_done: done=%b valid=%b want 0 0", done_o, part_valid_o);
        end
        start_i = 1'b1; mb_type_i = 3'd5; sub_mb_type_i = 12'd0;
        @(negedge clk);
        start_i = 1'b0;
        n_chk++;
        if (part_valid_o !== 1'b1 || geo !== 8'h0F || part_idx_o !== 4'd0 || part_last_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reserved_mb: v=%b geo=%h idx=%0d last=%b want 1 0f 0 1", part_valid_o, geo, part_idx_o, part_last_o);
        end
        @(negedge clk);
        n_chk++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reserved_mb done: done=%b busy=%b want 1 0", done_o, busy_o);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_16x16();
        test_16x8_8x16();
        test_8x8();
        test_8x8_stall();
        test_restart();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
